alu_share_arb: RTL and testbench
================================

Name: alu_share_arb

Overview:
- Shares one RV32I integer ALU between two requesters, e.g. requester 0 = execute stage and requester 1 = address/branch helper.
- Each requester has a valid/ready request channel and a valid/ready response channel.
- The arbiter selects one request per cycle and drives the ALU's f3/f7_b5/operand inputs combinationally.
- The ALU result is captured into a per-requester response register, so results appear one cycle after acceptance.

Parameters:
- XLEN, 32, operand/result width; must match the ALU datapath width.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req0_valid  in  1  requester 0 has an operation pending.
- req0_ready  out  1  requester 0 operation accepted this cycle.
- req0_f3  in  3  funct3 for requester 0.
- req0_f7_b5  in  1  funct7 bit 5 for requester 0 (SUB/SRA select).
- req0_a  in  XLEN  operand 1 for requester 0.
- req0_b  in  XLEN  operand 2 for requester 0.
- rsp0_valid  out  1  requester 0 result available.
- rsp0_ready  in  1  requester 0 consumes the result.
- rsp0_data  out  XLEN  requester 0 result.
- req1_valid, req1_ready, req1_f3, req1_f7_b5, req1_a, req1_b  as above, for requester 1.
- rsp1_valid, rsp1_ready, rsp1_data  as above, for requester 1.
- alu_f3  out  3  to ALU f3.
- alu_f7_b5  out  1  to ALU f7_b5.
- alu_i1  out  XLEN  to ALU alu_i1.
- alu_i2  out  XLEN  to ALU alu_i2.
- alu_o  in  XLEN  ALU result, combinational from alu_* outputs.

Behaviour:
- Reset (rst_n low, asynchronous):
  - rsp0_valid = rsp1_valid = 0.
  - rsp0_data = rsp1_data = 0.
  - last_grant = 1, so requester 0 wins the first tie.
- Eligibility: eligN = reqN_valid & (~rspN_valid | rspN_ready). A requester is blocked only when its response slot is full and not draining.
- Grant, combinational:
  - If only one requester is eligible, it is granted.
  - If both are eligible, the requester that is not last_grant is granted (round-robin).
  - If neither is eligible, no grant.
  - reqN_ready = grantN. At most one ready is high per cycle.
- ALU drive:
  - alu_* are taken from the granted requester.
  - With no grant, alu_* are taken from requester 0 (deterministic, no X).
- Accept (rising edge with grantN):
  - rspN_data <= alu_o.
  - rspN_valid <= 1.
  - last_grant <= N.
- Drain: rspN_valid & rspN_ready with no new grant to N clears rspN_valid. rspN_data holds its last value.
- Simultaneous drain and accept on the same N: rspN_valid stays 1 and rspN_data takes the new result. Single-requester throughput is 1 op/cycle.
- Latency: request accepted in cycle T, result valid in cycle T+1. Aggregate throughput is 1 op/cycle.
- No-grant cycle: last_grant is unchanged.
- Requester rules:
  - reqN payload must stay stable while reqN_valid=1 and reqN_ready=0.
  - Requesters must not drop valid before ready.
- Ordering: per requester, responses are returned in acceptance order (depth-1 slot, so trivially ordered).
- Reset asserted mid-operation discards all pending responses immediately. Outstanding requests are not replayed.
- All arithmetic and widths are owned by the ALU; the arbiter only multiplexes XLEN-bit operands and registers results.

Optional Feature:
- Macro: ALU_ARB_FIXED_PRIO_EN.
- Defined: requester 0 always wins when both are eligible, and last_grant is not implemented. Requester 1 is granted only when requester 0 is not eligible.
- Undefined: round-robin as specified above.

Test Plan:
- Reset release, req0 ADD (f3=000, f7_b5=0) a=5, b=3, rsp0_ready=1 -> req0_ready=1 in cycle T; rsp0_valid=1 and rsp0_data=8 in T+1; rsp1_valid stays 0.
- Both valid in the first cycle after reset: req0 SUB 10-4, req1 XOR 0xF0^0x0F -> req0 granted in T, rsp0_data=6 in T+1; req1 granted in T+1, rsp1_data=0xFF in T+2.
- Continuous contention for 8 cycles with both rsp_ready=1 -> grants alternate 0,1,0,1,...; each requester completes 4 ops.
- rsp0_ready=0 with rsp0 full, req0 and req1 both valid -> req0_ready=0 every cycle; req1 granted every cycle; asserting rsp0_ready=1 -> req0 granted that same cycle.
- Single requester streaming SRA 0x80000000>>4 (f3=101, f7_b5=1) with rsp_ready=1 every cycle -> back-to-back acceptance; rsp_data=0xF8000000 every cycle; rsp_valid never drops.
- rst_n pulsed low while rsp0_valid=1 and rsp1_valid=1 -> both clear asynchronously; after release, a tie grants req0 first.
- With ALU_ARB_FIXED_PRIO_EN defined and both requesters continuously valid and eligible -> req0 granted every cycle; req1_ready stays 0.

Source files
------------

// File: rtl/alu_share_arb_if.sv
// Bundle of request/response channels and ALU drive signals for alu_share_arb.
//   slave  : arbiter side (receives requests, returns responses, drives the ALU)
//   master : requester/ALU side (issues requests, consumes responses, returns alu_o)
// Signals:
//   reqN_valid/ready/f3/f7_b5/a/b : request channel of requester N (N = 0, 1)
//   rspN_valid/ready/data         : response channel of requester N
//   alu_f3/f7_b5/i1/i2            : operation and operands presented to the shared ALU
//   alu_o                         : combinational ALU result
interface alu_share_arb_if #(
  parameter int unsigned XLEN = 32
) ();
  logic            req0_valid;
  logic            req0_ready;
  logic [2:0]      req0_f3;
  logic            req0_f7_b5;
  logic [XLEN-1:0] req0_a;
  logic [XLEN-1:0] req0_b;
  logic            rsp0_valid;
  logic            rsp0_ready;
  logic [XLEN-1:0] rsp0_data;

  logic            req1_valid;
  logic            req1_ready;
  logic [2:0]      req1_f3;
  logic            req1_f7_b5;
  logic [XLEN-1:0] req1_a;
  logic [XLEN-1:0] req1_b;
  logic            rsp1_valid;
  logic            rsp1_ready;
  logic [XLEN-1:0] rsp1_data;

  logic [2:0]      alu_f3;
  logic            alu_f7_b5;
  logic [XLEN-1:0] alu_i1;
  logic [XLEN-1:0] alu_i2;
  logic [XLEN-1:0] alu_o;

  modport slave (
    input  req0_valid, req0_f3, req0_f7_b5, req0_a, req0_b, rsp0_ready,
    input  req1_valid, req1_f3, req1_f7_b5, req1_a, req1_b, rsp1_ready,
    input  alu_o,
    output req0_ready, rsp0_valid, rsp0_data,
    output req1_ready, rsp1_valid, rsp1_data,
    output alu_f3, alu_f7_b5, alu_i1, alu_i2
  );

  modport master (
    output req0_valid, req0_f3, req0_f7_b5, req0_a, req0_b, rsp0_ready,
    output req1_valid, req1_f3, req1_f7_b5, req1_a, req1_b, rsp1_ready,
    output alu_o,
    input  req0_ready, rsp0_valid, rsp0_data,
    input  req1_ready, rsp1_valid, rsp1_data,
    input  alu_f3, alu_f7_b5, alu_i1, alu_i2
  );
endinterface

// File: rtl/alu_share_arb.sv
// Two-requester arbiter in front of one shared RV32I integer ALU.
// One request is granted per cycle; its operation is driven to the ALU combinationally and
// the ALU result is registered into that requester's depth-1 response slot (result valid the
// cycle after acceptance). A requester is blocked only while its slot is full and not draining.
// Ports:
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : alu_share_arb_if.slave (request/response channels, ALU drive and result)
// Build option:
//   ALU_ARB_FIXED_PRIO_EN defined   -> requester 0 always wins a tie, no last_grant state
//   ALU_ARB_FIXED_PRIO_EN undefined -> round-robin tie break using last_grant
module alu_share_arb #(
  parameter int unsigned XLEN = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  alu_share_arb_if.slave bus
);

  logic            w_elig0;
  logic            w_elig1;
  logic            w_grant0;
  logic            w_grant1;

  logic            r_rsp0_valid;
  logic [XLEN-1:0] r_rsp0_data;
  logic            r_rsp1_valid;
  logic [XLEN-1:0] r_rsp1_data;

  // A full slot that drains this cycle can accept a new result on the same edge.
  assign w_elig0 = bus.req0_valid & (~r_rsp0_valid | bus.rsp0_ready);
  assign w_elig1 = bus.req1_valid & (~r_rsp1_valid | bus.rsp1_ready);

`ifdef ALU_ARB_FIXED_PRIO_EN
  assign w_grant0 = w_elig0;
  assign w_grant1 = w_elig1 & ~w_elig0;
`else
  // Index of the requester granted most recently; reset to 1 so requester 0 wins first tie.
  logic r_last_grant;

  assign w_grant0 = w_elig0 & (~w_elig1 | r_last_grant);
  assign w_grant1 = w_elig1 & (~w_elig0 | ~r_last_grant);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
    end else if (w_grant0) begin
      r_last_grant <= 1'b0;
    end else if (w_grant1) begin
      r_last_grant <= 1'b1;
    end
  end
`endif

  assign bus.req0_ready = w_grant0;
  assign bus.req1_ready = w_grant1;

  // ALU drive follows requester 0 unless requester 1 holds the grant, so idle cycles are
  // deterministic.
  always_comb begin
    bus.alu_f3    = bus.req0_f3;
    bus.alu_f7_b5 = bus.req0_f7_b5;
    bus.alu_i1    = bus.req0_a;
    bus.alu_i2    = bus.req0_b;
    if (w_grant1) begin
      bus.alu_f3    = bus.req1_f3;
      bus.alu_f7_b5 = bus.req1_f7_b5;
      bus.alu_i1    = bus.req1_a;
      bus.alu_i2    = bus.req1_b;
    end
  end

  // Response slots: accept wins over drain, data holds after drain.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp0_valid <= 1'b0;
      r_rsp0_data  <= '0;
    end else if (w_grant0) begin
      r_rsp0_valid <= 1'b1;
      r_rsp0_data  <= bus.alu_o;
    end else if (bus.rsp0_ready) begin
      r_rsp0_valid <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rsp1_valid <= 1'b0;
      r_rsp1_data  <= '0;
    end else if (w_grant1) begin
      r_rsp1_valid <= 1'b1;
      r_rsp1_data  <= bus.alu_o;
    end else if (bus.rsp1_ready) begin
      r_rsp1_valid <= 1'b0;
    end
  end

  assign bus.rsp0_valid = r_rsp0_valid;
  assign bus.rsp0_data  = r_rsp0_data;
  assign bus.rsp1_valid = r_rsp1_valid;
  assign bus.rsp1_data  = r_rsp1_data;

endmodule

// File: tb/tb_alu_share_arb.sv
// Self-checking bench for alu_share_arb: directed scenarios with literal expectations, then
// randomized traffic compared every cycle against a behavioural model of the arbiter.
module tb_alu_share_arb;
  localparam int unsigned XLEN = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  alu_share_arb_if #(.XLEN(XLEN)) bus ();

  alu_share_arb #(.XLEN(XLEN)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  // Reference RV32I ALU standing in for the real datapath.
  function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic b5,
                                          input logic [31:0] a, input logic [31:0] b);
    logic [4:0] sh;
    sh = b[4:0];
    case (f3)
      3'd0:    return b5 ? a - b : a + b;
      3'd1:    return a << sh;
      3'd2:    return {31'd0, $signed(a) < $signed(b)};
      3'd3:    return {31'd0, a < b};
      3'd4:    return a ^ b;
      3'd5:    return b5 ? $unsigned($signed(a) >>> sh) : a >> sh;
      3'd6:    return a | b;
      default: return a & b;
    endcase
  endfunction

  assign bus.alu_o = alu_ref(bus.alu_f3, bus.alu_f7_b5, bus.alu_i1, bus.alu_i2);

  int n_chk = 0;
  int n_err = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Which requester wins, from the rules: lone eligible wins; a tie goes to the one that was
  // not granted last (or always to 0 with fixed priority); -1 means no grant.
  function automatic int pick(input bit e0, input bit e1, input int last);
    if (e0 && e1) begin
`ifdef ALU_ARB_FIXED_PRIO_EN
      return 0;
`else
      return (last == 0) ? 1 : 0;
`endif
    end
    if (e0) return 0;
    if (e1) return 1;
    return -1;
  endfunction

  // Behavioural model state: response slots and last winner.
  bit          m_v[2]   = '{0, 0};
  logic [31:0] m_d[2]   = '{0, 0};
  int          m_last   = 1;
  bit          nx_v[2]  = '{0, 0};
  logic [31:0] nx_d[2]  = '{0, 0};
  int          nx_last  = 1;
  bit          chk_en   = 0;
  bit          seen_rdy0 = 0;
  bit          seen_rdy1 = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v = '{0, 0};
      m_d = '{0, 0};
      m_last = 1;
    end else begin
      m_v = nx_v;
      m_d = nx_d;
      m_last = nx_last;
    end
  end

  // Compare process: mid-cycle, check every output and derive the model's next state.
  always @(negedge clk) begin
    bit e0, e1;
    int g;
    logic [2:0]  p_f3[2];
    logic        p_b5[2];
    logic [31:0] p_a[2];
    logic [31:0] p_b[2];
    bit          rr[2];
    int          src;
    seen_rdy0 = bus.req0_ready;
    seen_rdy1 = bus.req1_ready;
    if (!rst_n) begin
      nx_v = '{0, 0};
      nx_d = '{0, 0};
      nx_last = 1;
    end else if (chk_en) begin
      p_f3 = '{bus.req0_f3, bus.req1_f3};
      p_b5 = '{bus.req0_f7_b5, bus.req1_f7_b5};
      p_a  = '{bus.req0_a, bus.req1_a};
      p_b  = '{bus.req0_b, bus.req1_b};
      rr   = '{bus.rsp0_ready, bus.rsp1_ready};
      e0 = bus.req0_valid && (!m_v[0] || rr[0]);
      e1 = bus.req1_valid && (!m_v[1] || rr[1]);
      g = pick(e0, e1, m_last);
      check("req0_ready", 32'(bus.req0_ready), 32'(g == 0));
      check("req1_ready", 32'(bus.req1_ready), 32'(g == 1));
      src = (g == 1) ? 1 : 0;
      check("alu_f3", 32'(bus.alu_f3), 32'(p_f3[src]));
      check("alu_f7_b5", 32'(bus.alu_f7_b5), 32'(p_b5[src]));
      check("alu_i1", bus.alu_i1, p_a[src]);
      check("alu_i2", bus.alu_i2, p_b[src]);
      check("rsp0_valid", 32'(bus.rsp0_valid), 32'(m_v[0]));
      check("rsp1_valid", 32'(bus.rsp1_valid), 32'(m_v[1]));
      check("rsp0_data", bus.rsp0_data, m_d[0]);
      check("rsp1_data", bus.rsp1_data, m_d[1]);
      nx_v = m_v;
      nx_d = m_d;
      nx_last = m_last;
      for (int n = 0; n < 2; n++) begin
        if (g == n) begin
          nx_v[n] = 1;
          nx_d[n] = alu_ref(p_f3[n], p_b5[n], p_a[n], p_b[n]);
          nx_last = n;
        end else if (rr[n]) begin
          nx_v[n] = 0;
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req0(input bit v, input logic [2:0] f3, input bit b5,
                          input logic [31:0] a, input logic [31:0] b);
    bus.req0_valid = v; bus.req0_f3 = f3; bus.req0_f7_b5 = b5; bus.req0_a = a; bus.req0_b = b;
  endtask

  task automatic set_req1(input bit v, input logic [2:0] f3, input bit b5,
                          input logic [31:0] a, input logic [31:0] b);
    bus.req1_valid = v; bus.req1_f3 = f3; bus.req1_f7_b5 = b5; bus.req1_a = a; bus.req1_b = b;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    set_req0(0, 3'd0, 0, 0, 0);
    set_req1(0, 3'd0, 0, 0, 0);
    bus.rsp0_ready = 1'b1;
    bus.rsp1_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  initial begin
    int c0, c1;
    set_req0(0, 3'd0, 0, 0, 0);
    set_req1(0, 3'd0, 0, 0, 0);
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    #2;
    check("reset rsp0_valid", 32'(bus.rsp0_valid), 32'd0);
    check("reset rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    check("reset rsp0_data", bus.rsp0_data, 32'd0);
    check("reset rsp1_data", bus.rsp1_data, 32'd0);
    do_reset();
    chk_en = 1;

    // ADD 5+3 from requester 0.
    set_req0(1, 3'b000, 0, 32'd5, 32'd3);
    #1 check("t1 req0_ready", 32'(bus.req0_ready), 32'd1);
    tick();
    set_req0(0, 3'b000, 0, 32'd5, 32'd3);
    check("t1 rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
    check("t1 rsp0_data", bus.rsp0_data, 32'd8);
    check("t1 rsp1_valid", 32'(bus.rsp1_valid), 32'd0);
    tick();

    // Tie straight out of reset: SUB 10-4 vs XOR 0xF0^0x0F.
    do_reset();
    set_req0(1, 3'b000, 1, 32'd10, 32'd4);
    set_req1(1, 3'b100, 0, 32'hF0, 32'h0F);
    #1 check("t2 req0_ready", 32'(bus.req0_ready), 32'd1);
    check("t2 req1_ready", 32'(bus.req1_ready), 32'd0);
    tick();
    set_req0(0, 3'b000, 0, 0, 0);
    check("t2 rsp0_data", bus.rsp0_data, 32'd6);
    #1 check("t2 req1_ready", 32'(bus.req1_ready), 32'd1);
    tick();
    set_req1(0, 3'b000, 0, 0, 0);
    check("t2 rsp1_valid", 32'(bus.rsp1_valid), 32'd1);
    check("t2 rsp1_data", bus.rsp1_data, 32'hFF);

    // Continuous contention for 8 cycles.
    set_req0(1, 3'b000, 0, 32'd1, 32'd1);
    set_req1(1, 3'b110, 0, 32'h10, 32'h01);
    c0 = 0;
    c1 = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      c0 += int'(bus.req0_ready);
      c1 += int'(bus.req1_ready);
      tick();
    end
`ifdef ALU_ARB_FIXED_PRIO_EN
    check("t3 grants0", 32'(c0), 32'd8);
    check("t3 grants1", 32'(c1), 32'd0);
`else
    check("t3 grants0", 32'(c0), 32'd4);
    check("t3 grants1", 32'(c1), 32'd4);
`endif

    // Requester 0 blocked by a full, non-draining slot.
    bus.rsp0_ready = 1'b0;
    tick();
    tick();
    for (int i = 0; i < 4; i++) begin
      #1 check("t4 req0_ready blocked", 32'(bus.req0_ready), 32'd0);
      check("t4 req1_ready", 32'(bus.req1_ready), 32'd1);
      tick();
    end
    bus.rsp0_ready = 1'b1;
    #1 check("t4 req0_ready unblocked", 32'(bus.req0_ready), 32'd1);
    tick();

    // Single-requester SRA streaming.
    set_req1(0, 3'b000, 0, 0, 0);
    set_req0(1, 3'b101, 1, 32'h8000_0000, 32'd4);
    for (int i = 0; i < 6; i++) begin
      #1 check("t5 req0_ready", 32'(bus.req0_ready), 32'd1);
      tick();
      check("t5 rsp0_valid", 32'(bus.rsp0_valid), 32'd1);
      check("t5 rsp0_data", bus.rsp0_data, 32'hF800_0000);
    end

    // Asynchronous reset with both slots full.
    bus.rsp0_ready = 1'b0;
    bus.rsp1_ready = 1'b0;
    set_req1(1, 3'b110, 0, 32'h3, 32'h4);
    tick();
    tick();
    check("t6 rsp0_valid full", 32'(bus.rsp0_valid), 32'd1);
    check("t6 rsp1_valid full", 32'(bus.rsp1_valid), 32'd1);
    #1 rst_n = 1'b0;
    #1 check("t6 rsp0_valid cleared", 32'(bus.rsp0_valid), 32'd0);
    check("t6 rsp1_valid cleared", 32'(bus.rsp1_valid), 32'd0);
    check("t6 rsp0_data cleared", bus.rsp0_data, 32'd0);
    tick();
    rst_n = 1'b1;
    #1 check("t6 tie req0_ready", 32'(bus.req0_ready), 32'd1);
    check("t6 tie req1_ready", 32'(bus.req1_ready), 32'd0);
    tick();

    // Randomized traffic; payload held while a request waits.
    for (int c = 0; c < 3000; c++) begin
      if (!(bus.req0_valid && !seen_rdy0)) begin
        set_req0(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom);
      end
      if (!(bus.req1_valid && !seen_rdy1)) begin
        set_req1(($urandom_range(0, 3) != 0), 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)),
                 $urandom, $urandom);
      end
      bus.rsp0_ready = ($urandom_range(0, 3) != 0);
      bus.rsp1_ready = ($urandom_range(0, 3) != 0);
      tick();
    end
    set_req0(0, 3'd0, 0, 0, 0);
    set_req1(0, 3'd0, 0, 0, 0);
    tick();
    tick();

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
